// File: rtl/enc_pkg.sv
// Shared encodings for the encoder control path and the block scheduler
// that feeds it.
package enc_pkg;

  // Default block-length width (bits per code block).
  localparam int LEN_W_DEFAULT = 13;

  // Width of requester ids; covers up to 8 requesters.
  localparam int ID_W = 3;

  // Encoder control FSM states, as seen on the encoder state bus.
  typedef enum logic [2:0] {
    ENC_INIT         = 3'd0,
    ENC_RECORD       = 3'd1,
    ENC_WAIT_INT     = 3'd2,
    ENC_OPERATE      = 3'd3,
    ENC_LAST_OPERATE = 3'd4,
    ENC_TAIL         = 3'd5,
    ENC_WAIT_TAIL    = 3'd6,
    ENC_LAST_TAIL    = 3'd7
  } enc_state_t;

  // Scheduler states.
  typedef enum logic [1:0] {
    SCH_IDLE   = 2'd0,
    SCH_START  = 2'd1,
    SCH_RUN    = 2'd2,
    SCH_FINISH = 2'd3
  } sch_state_t;

  // Requester id that follows 'id' in round-robin order (wraps at nreq).
  function automatic logic [ID_W-1:0] rr_after(input logic [ID_W-1:0] id, input int nreq);
    if (int'(id) >= nreq - 1) begin
      return '0;
    end
    return id + ID_W'(1);
  endfunction

endpackage

// File: rtl/enc_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr (modulo NREQ) wins. The pointer itself is owned by the caller.
module enc_rr_arbiter
  import enc_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            enable,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] id,
  output logic            any
);

  // Requests rotated so that position 0 is the pointer's requester.
  logic [NREQ-1:0] rot_req;
  logic [NREQ-1:0] rot_oh  [NREQ];
  logic [ID_W-1:0] rot_idx [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [ID_W:0] sum;
    assign sum          = {1'b0, ptr} + (ID_W+1)'(gi);
    assign rot_idx[gi]  = (sum >= (ID_W+1)'(NREQ)) ? ID_W'(sum - (ID_W+1)'(NREQ))
                                                    : sum[ID_W-1:0];
    assign rot_oh[gi]   = NREQ'(1) << rot_idx[gi];
    assign rot_req[gi]  = |(req & rot_oh[gi]);
  end

  // Pick the lowest rotated position that is requesting; later (lower)
  // iterations overwrite earlier ones so position 0 has top priority.
  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (enable && rot_req[k]) begin
        gnt = rot_oh[k];
        id  = rot_idx[k];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enc_scheduler.sv
// Round-robin scheduler sharing one encoder core between NREQ code-block
// requesters: grants a block, starts the encoder, generates the operate and
// tail-wait terminal pulses from the encoder state bus, and reports done.
module enc_scheduler
  import enc_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int LEN_W     = LEN_W_DEFAULT,
  parameter int TAIL_WAIT = 2
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]       gnt,
  input  logic                  enc_ready,
  input  logic [2:0]            enc_state,
  output logic                  cbs_ready,
  output logic                  counter,
  output logic                  tail_counter,
  output logic                  busy,
  output logic [2:0]            active_id,
  output logic                  done,
  output logic [2:0]            done_id,
  output logic                  err
);

  localparam int              TL_W    = $clog2(TAIL_WAIT) + 1;
  localparam logic [TL_W-1:0] TL_LAST = TL_W'(TAIL_WAIT - 1);

  sch_state_t       state_reg;
  sch_state_t       state_next;
  logic [ID_W-1:0]  ptr_reg;
  logic [ID_W-1:0]  active_id_reg;
  logic [ID_W-1:0]  done_id_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] len_m1;
  logic [LEN_W-1:0] op_cnt_reg;
  logic [TL_W-1:0]  tl_cnt_reg;

  logic             arb_en;
  logic             arb_any;
  logic [NREQ-1:0]  arb_gnt;
  logic [ID_W-1:0]  arb_id;
  logic [LEN_W-1:0] len_masked [NREQ];
  logic [LEN_W-1:0] sel_len;
  logic             zero_len;
  logic             grant_ok;

  enc_state_t       enc_st;
  logic             in_run;
  logic             enc_op;
  logic             enc_wt;
  logic             enc_lt;

  assign enc_st = enc_state_t'(enc_state);
  assign in_run = (state_reg == SCH_RUN);
  assign enc_op = (enc_st == ENC_OPERATE);
  assign enc_wt = (enc_st == ENC_WAIT_TAIL);
  assign enc_lt = (enc_st == ENC_LAST_TAIL);

  // Arbitrate only while idle with the encoder back in INIT. Reset also
  // blocks arbitration so no grant escapes while aclr is held.
  assign arb_en = (state_reg == SCH_IDLE) && enc_ready && !aclr;

  enc_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_reg),
    .enable (arb_en),
    .gnt    (arb_gnt),
    .id     (arb_id),
    .any    (arb_any)
  );

  // AND-OR mux of the winner's block length using the one-hot grant.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
    assign len_masked[gi] = req_len[gi*LEN_W +: LEN_W] & {LEN_W{arb_gnt[gi]}};
  end

  // Collapse the masked lengths; at most one slice is non-zero.
  always_comb begin
    sel_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_len = sel_len | len_masked[i];
    end
  end

  assign zero_len = (sel_len == '0);
  assign grant_ok = arb_any && !zero_len;
  assign gnt      = arb_gnt;
  assign err      = arb_any && zero_len;

  // Terminal decodes: combinational on registered counters and the live
  // encoder state, forced low outside RUN.
  assign len_m1       = len_reg - LEN_W'(1);
  assign counter      = in_run && enc_op && (op_cnt_reg == len_m1);
  assign tail_counter = in_run && enc_wt && (tl_cnt_reg == TL_LAST);

  assign active_id = active_id_reg;
  assign done_id   = done_id_reg;

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next = state_reg;
    cbs_ready  = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      SCH_IDLE: begin
        busy = 1'b0;
        if (grant_ok) begin
          state_next = SCH_START;
        end
      end
      SCH_START: begin
        cbs_ready  = 1'b1;
        state_next = SCH_RUN;
      end
      SCH_RUN: begin
        if (enc_lt) begin
          state_next = SCH_FINISH;
        end
      end
      SCH_FINISH: begin
        done       = 1'b1;
        state_next = SCH_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = SCH_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_reg <= SCH_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Grant bookkeeping: every grant (zero-length ones too) moves the pointer
  // past the winner and records its id and length.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      ptr_reg       <= '0;
      active_id_reg <= '0;
      len_reg       <= '0;
    end else if (arb_any) begin
      ptr_reg       <= rr_after(arb_id, NREQ);
      active_id_reg <= arb_id;
      len_reg       <= sel_len;
    end
  end

  // Capture the completing id as the encoder signals its last tail cycle.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      done_id_reg <= '0;
    end else if (in_run && enc_lt) begin
      done_id_reg <= active_id_reg;
    end
  end

  // Phase counters: count OPERATE / WAIT_TAIL cycles while running,
  // held at zero in every other scheduler state.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      op_cnt_reg <= '0;
      tl_cnt_reg <= '0;
    end else if (!in_run) begin
      op_cnt_reg <= '0;
      tl_cnt_reg <= '0;
    end else begin
      if (enc_op) begin
        op_cnt_reg <= op_cnt_reg + LEN_W'(1);
      end
      if (enc_wt) begin
        tl_cnt_reg <= tl_cnt_reg + TL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_enc_scheduler.sv
// Self-checking bench for enc_scheduler with a behavioural encoder FSM and
// a block-level reference model of the scheduler.
module tb_enc_scheduler;
  import enc_pkg::*;

  localparam int NREQ      = 4;
  localparam int LEN_W     = 13;
  localparam int TAIL_WAIT = 2;

  logic                  clock = 1'b0;
  logic                  aclr;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       gnt;
  logic                  enc_ready;
  logic [2:0]            enc_state;
  logic                  cbs_ready, counter, tail_counter, busy, done, err;
  logic [2:0]            active_id, done_id;

  always #5 clock = ~clock;

  enc_scheduler #(.NREQ(NREQ), .LEN_W(LEN_W), .TAIL_WAIT(TAIL_WAIT)) dut (
    .clock(clock), .aclr(aclr), .req(req), .req_len(req_len), .gnt(gnt),
    .enc_ready(enc_ready), .enc_state(enc_state), .cbs_ready(cbs_ready),
    .counter(counter), .tail_counter(tail_counter), .busy(busy),
    .active_id(active_id), .done(done), .done_id(done_id), .err(err)
  );

  // Behavioural encoder control FSM (RECORD lasts 2 cycles) with an
  // override used to hold the bus in a non-INIT state.
  enc_state_t enc_q;
  enc_state_t ovr_state;
  logic       ovr_en;
  int         rec_cnt;

  assign enc_state = ovr_en ? ovr_state : enc_q;
  assign enc_ready = (enc_state == ENC_INIT);

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      enc_q   <= ENC_INIT;
      rec_cnt <= 0;
    end else begin
      case (enc_q)
        ENC_INIT:         if (cbs_ready) begin enc_q <= ENC_RECORD; rec_cnt <= 0; end
        ENC_RECORD:       if (rec_cnt == 1) enc_q <= ENC_WAIT_INT; else rec_cnt <= rec_cnt + 1;
        ENC_WAIT_INT:     enc_q <= ENC_OPERATE;
        ENC_OPERATE:      if (counter) enc_q <= ENC_LAST_OPERATE;
        ENC_LAST_OPERATE: enc_q <= ENC_TAIL;
        ENC_TAIL:         enc_q <= ENC_WAIT_TAIL;
        ENC_WAIT_TAIL:    if (tail_counter) enc_q <= ENC_LAST_TAIL;
        ENC_LAST_TAIL:    enc_q <= ENC_INIT;
        default:          enc_q <= ENC_INIT;
      endcase
    end
  end

  // Counters and reference-model state.
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int m_ptr, m_len, m_id, m_act, m_done_id, m_op, m_tl;
  bit m_busy, m_cbs_due, m_run, m_done_due;

  // Per-cycle snapshots and event timestamps.
  logic [NREQ-1:0] snap_gnt;
  logic snap_err, snap_cbs, snap_busy, snap_done;
  logic [2:0] snap_did;
  int t_gnt, t_cbs, t_rec, t_first_op, t_counter, t_lo, t_lt, t_done;
  int n_op, n_wt, n_done, n_gnt_busy;

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            err;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int oh2id(input logic [NREQ-1:0] oh);
    for (int i = 0; i < NREQ; i++) if (oh[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_len = 0; m_id = 0; m_act = 0; m_done_id = 0; m_op = 0; m_tl = 0;
    m_busy = 0; m_cbs_due = 0; m_run = 0; m_done_due = 0;
  endtask

  // Compare all outputs against the block-level model, then advance it.
  task automatic check_cycle();
    logic [NREQ-1:0] e_gnt;
    logic e_err, e_cbs, e_cnt, e_tc, e_busy, e_done;
    logic [2:0] e_act, e_did;
    int w, L;
    bit was_run;
    e_gnt = '0; e_err = 0; e_cbs = 0; e_cnt = 0; e_tc = 0; e_busy = 0; e_done = 0;
    e_act = '0; e_did = '0; w = -1; L = 0;
    if (aclr) begin
      model_reset();
    end else begin
      if (!m_busy && enc_ready && req != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        end
        e_gnt = NREQ'(1) << w;
        L     = int'(req_len[w*LEN_W +: LEN_W]);
        e_err = (L == 0);
      end
      e_cbs  = m_cbs_due;
      e_busy = m_busy;
      e_done = m_done_due;
      e_cnt  = m_run && (enc_state == ENC_OPERATE) && (m_op == m_len - 1);
      e_tc   = m_run && (enc_state == ENC_WAIT_TAIL) && (m_tl == TAIL_WAIT - 1);
      e_act  = 3'(m_act);
      e_did  = 3'(m_done_id);
    end
    n_cmp++;
    if ({gnt, err, cbs_ready, counter, tail_counter, busy, done, active_id, done_id} !==
        {e_gnt, e_err, e_cbs, e_cnt, e_tc, e_busy, e_done, e_act, e_did}) begin
      n_bad++;
      $display("FAIL cycle%0d outputs: got gnt=%b err=%b cbs=%b cnt=%b tcnt=%b busy=%b done=%b act=%0d did=%0d required gnt=%b err=%b cbs=%b cnt=%b tcnt=%b busy=%b done=%b act=%0d did=%0d",
               cyc, gnt, err, cbs_ready, counter, tail_counter, busy, done, active_id, done_id,
               e_gnt, e_err, e_cbs, e_cnt, e_tc, e_busy, e_done, e_act, e_did);
    end
    if (!aclr) begin
      was_run = m_run;
      if (e_done) begin m_done_due = 0; m_busy = 0; end
      if (was_run) begin
        if (enc_state == ENC_OPERATE)   m_op++;
        if (enc_state == ENC_WAIT_TAIL) m_tl++;
        if (enc_state == ENC_LAST_TAIL) begin m_run = 0; m_done_due = 1; m_done_id = m_id; end
      end
      if (e_cbs) begin m_cbs_due = 0; m_run = 1; m_op = 0; m_tl = 0; end
      if (w >= 0) begin
        m_ptr = (w + 1) % NREQ;
        m_act = w;
        if (L != 0) begin m_busy = 1; m_cbs_due = 1; m_len = L; m_id = w; end
      end
    end
    // Snapshots and event timestamps from the observed signals.
    snap_gnt = gnt; snap_err = err; snap_cbs = cbs_ready; snap_busy = busy;
    snap_done = done; snap_did = done_id;
    if (gnt != '0) begin t_gnt = cyc; if (busy) n_gnt_busy++; end
    if (cbs_ready) begin t_cbs = cyc; n_op = 0; n_wt = 0; t_rec = -1; t_first_op = -1; end
    if (enc_state == ENC_RECORD && t_rec < 0) t_rec = cyc;
    if (enc_state == ENC_OPERATE) begin n_op++; if (t_first_op < 0) t_first_op = cyc; end
    if (counter) t_counter = cyc;
    if (enc_state == ENC_LAST_OPERATE) t_lo = cyc;
    if (enc_state == ENC_WAIT_TAIL) n_wt++;
    if (enc_state == ENC_LAST_TAIL) t_lt = cyc;
    if (done) begin t_done = cyc; n_done++; end
  endtask

  // One clock: check at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    req  = '0;
    aclr = 1'b1;
    tick();
    tick();
    aclr = 1'b0;
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  task automatic wait_gnt(input int limit, output logic [NREQ-1:0] g);
    g = '0;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (snap_gnt != '0) begin g = snap_gnt; return; end
    end
    n_cmp++; n_bad++;
    $display("FAIL gnt_timeout: got no grant required one within %0d cycles", limit);
  endtask

  task automatic wait_done(input int limit);
    for (int k = 0; k < limit; k++) begin
      tick();
      if (snap_done) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL done_timeout: got no done required one within %0d cycles", limit);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish required one before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] g;
    int exp_rr[5];
    int done_before, cnt;

    tbl[0] = '{req: 4'b0100, gnt: 4'b0100, err: 1'b1};
    tbl[1] = '{req: 4'b0011, gnt: 4'b0001, err: 1'b1};
    tbl[2] = '{req: 4'b0000, gnt: 4'b0000, err: 1'b0};
    tbl[3] = '{req: 4'b1111, gnt: 4'b0010, err: 1'b1};
    tbl[4] = '{req: 4'b1001, gnt: 4'b1000, err: 1'b1};
    tbl[5] = '{req: 4'b1000, gnt: 4'b1000, err: 1'b1};
    tbl[6] = '{req: 4'b0110, gnt: 4'b0010, err: 1'b1};
    tbl[7] = '{req: 4'b0100, gnt: 4'b0100, err: 1'b1};
    tbl[8] = '{req: 4'b1111, gnt: 4'b1000, err: 1'b1};
    exp_rr = '{0, 1, 2, 3, 0};

    aclr = 1'b1; req = '0; req_len = '0; ovr_en = 1'b0; ovr_state = ENC_INIT;
    t_gnt = -1; t_cbs = -1; t_rec = -1; t_first_op = -1; t_counter = -1;
    t_lo = -1; t_lt = -1; t_done = -1; n_op = 0; n_wt = 0; n_done = 0; n_gnt_busy = 0;
    model_reset();

    // Reset state.
    tick();
    chk("reset_outputs", {gnt, err, cbs_ready, counter, tail_counter, busy, done, active_id, done_id}, 0);
    tick();
    aclr = 1'b0;

    // Zero-length grants: round-robin order and err pulses, no block starts.
    for (int r = 0; r < 9; r++) begin
      req = tbl[r].req;
      tick();
      chk("tbl_gnt", snap_gnt, tbl[r].gnt);
      chk("tbl_err", snap_err, tbl[r].err);
      chk("tbl_no_cbs", snap_cbs, 0);
    end

    // Single block, length 8.
    do_reset();
    req = 4'b0001; set_len(0, 8);
    wait_gnt(20, g);
    req = '0;
    chk("single_gnt", g, 4'b0001);
    wait_done(200);
    chk("single_cbs_lat", t_cbs - t_gnt, 1);
    chk("single_rec_lat", t_rec - t_gnt, 2);
    chk("single_op_cycles", n_op, 8);
    chk("single_wt_cycles", n_wt, TAIL_WAIT);
    chk("single_done_lat", t_done - t_lt, 1);
    chk("single_done_id", snap_did, 0);

    // Length 1 on requester 1.
    req = 4'b0010; set_len(1, 1);
    wait_gnt(20, g);
    req = '0;
    wait_done(200);
    chk("len1_op_cycles", n_op, 1);
    chk("len1_counter_first", t_counter, t_first_op);
    chk("len1_last_op_next", t_lo, t_counter + 1);
    chk("len1_done_id", snap_did, 1);

    // Round robin with all requests held high.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_len(i, 4);
    req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(200, g);
      chk("rr_order", oh2id(g), exp_rr[k]);
      if (k > 0) chk("rr_gap", (t_gnt - t_lt >= 2) ? 1 : 0, 1);
    end
    req = '0;
    wait_done(200);
    chk("rr_no_overlap", n_gnt_busy, 0);

    // Reset in the middle of a long OPERATE phase.
    do_reset();
    req = 4'b0100; set_len(2, 100);
    wait_gnt(20, g);
    req = '0;
    for (int k = 0; k < 100 && n_op < 10; k++) tick();
    done_before = n_done;
    req = 4'b1010; set_len(1, 5); set_len(3, 5);
    aclr = 1'b1;
    #1;
    chk("aclr_immediate", {gnt, err, cbs_ready, counter, tail_counter, busy, done, active_id, done_id}, 0);
    tick();
    tick();
    aclr = 1'b0;
    wait_gnt(20, g);
    chk("post_reset_gnt", g, 4'b0010);
    chk("no_done_on_reset", n_done, done_before);
    req = '0;
    wait_done(200);

    // Encoder held away from INIT: no grant until it returns.
    ovr_state = ENC_RECORD; ovr_en = 1'b1;
    req = 4'b1000; set_len(3, 3);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin tick(); if (snap_gnt != '0) cnt++; end
    chk("not_ready_no_gnt", cnt, 0);
    ovr_en = 1'b0;
    wait_gnt(3, g);
    chk("ready_gnt3", g, 4'b1000);
    req = '0;
    wait_done(200);

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (snap_gnt[i]) req[i] = 1'b0;
        else if (req[i] && $urandom_range(0, 29) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b1;
          set_len(i, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20)));
        end
      end
      aclr = ($urandom_range(0, 799) == 0);
      tick();
    end
    aclr = 1'b0;
    req  = '0;
    for (int k = 0; k < 300 && (snap_busy || busy); k++) tick();
    chk("drain_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
